// File: rtl/rca_pkg.sv
// Shared helpers for the pipelined ripple-carry adder slice.
// Parameter legality and derived segment width live here.
package rca_pkg;

    function automatic bit rca_params_ok(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && (stages <= width)
            && ((width % stages) == 0);
    endfunction

    function automatic int rca_seg_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, the unit of every ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_segment.sv
// W-bit ripple of full_adder cells; cmsb is the carry into the top bit.
module rca_segment
    import rca_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    (* keep = "true" *) logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[W];
    assign cmsb = c[W-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Ripple adder/subtractor cut into STAGES registered segments with
// operand skew and a whole-pipeline stall on backpressure.
module pipelined_rca_adder
    import rca_pkg::*;
#(
    parameter int WIDTH  = 128,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = rca_seg_width(WIDTH, STAGES);

    if (!rca_params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_rca_adder: illegal WIDTH/STAGES");
    end

    logic             en;
    logic             c0;
    logic [WIDTH-1:0] b_eff;
    logic             ovf_d;
    logic             ovf_q;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Stage k still owns the operand slices k..STAGES-1.
        localparam int OPW = (STAGES - k) * SEG;
        localparam int SW  = (k + 1) * SEG;

        logic [OPW-1:0] src_a;
        logic [OPW-1:0] src_b;
        logic [SEG-1:0] seg_sum;
        logic           seg_cin;
        logic           seg_cout;
        logic           vin;
        logic           v_d, v_q;
        logic           c_d, c_q;
        logic [SW-1:0]  s_d, s_q;

        if (k == 0) begin : g_src
            assign src_a   = a;
            assign src_b   = b_eff;
            assign seg_cin = c0;
            assign vin     = in_valid;
            always_comb s_d = seg_sum;
        end else begin : g_src
            assign src_a   = g_st[k-1].g_hold.a_q;
            assign src_b   = g_st[k-1].g_hold.b_q;
            assign seg_cin = g_st[k-1].c_q;
            assign vin     = g_st[k-1].v_q;
            always_comb s_d = {seg_sum, g_st[k-1].s_q};
        end

        if (k == STAGES - 1) begin : g_seg
            logic seg_cmsb;
            rca_segment #(.W(SEG)) u_seg (
                .a    (src_a[SEG-1:0]),
                .b    (src_b[SEG-1:0]),
                .cin  (seg_cin),
                .sum  (seg_sum),
                .cout (seg_cout),
                .cmsb (seg_cmsb)
            );
            always_comb ovf_d = seg_cmsb ^ seg_cout;
        end else begin : g_seg
            logic cmsb_unused;
            rca_segment #(.W(SEG)) u_seg (
                .a    (src_a[SEG-1:0]),
                .b    (src_b[SEG-1:0]),
                .cin  (seg_cin),
                .sum  (seg_sum),
                .cout (seg_cout),
                .cmsb (cmsb_unused)
            );
        end

        if (k < STAGES - 1) begin : g_hold
            logic [OPW-SEG-1:0] a_d, a_q;
            logic [OPW-SEG-1:0] b_d, b_q;

            always_comb begin
                a_d = src_a[OPW-1:SEG];
                b_d = src_b[OPW-1:SEG];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        always_comb begin
            v_d = vin;
            c_d = seg_cout;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_d;
                c_q <= c_d;
                s_q <= s_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign sum       = g_st[STAGES-1].s_q;
    assign cout      = g_st[STAGES-1].c_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed and random scoreboard bench for pipelined_rca_adder.
module tb_pipelined_rca_adder;

    localparam int WIDTH = 128;
    parameter int STAGES = 4;

    typedef logic [WIDTH:0] cv_t;
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    res_t q[$];
    res_t exp_in;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_pop  = 0;
    int   n_push = 0;

    pipelined_rca_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input cv_t obs, input cv_t exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic ci, input logic sb);
        res_t r;
        logic [WIDTH-1:0] ye;
        logic [WIDTH:0]   t;
        ye = sb ? ~y : y;
        t = {1'b0, x} + {1'b0, ye} + cv_t'(sb ? 1'b1 : ci);
        r.sum  = t[WIDTH-1:0];
        r.cout = t[WIDTH];
        r.ovf  = (x[WIDTH-1] == ye[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input logic sb, input res_t e);
        a = x;
        b = y;
        cin = ci;
        sub = sb;
        exp_in = e;
        in_valid = 1'b1;
    endtask

    // Called just after a falling edge; evaluates one handshake cycle.
    task automatic tick(output bit acc);
        res_t e;
        #1;
        acc = 1'b0;
        if (rst_n) begin
            check("in_ready", cv_t'(in_ready),
                  cv_t'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                n_pop++;
                if (q.size() == 0) begin
                    check("unexpected_out", cv_t'(1), cv_t'(0));
                end else begin
                    e = q.pop_front();
                    check("sum", cv_t'(sum), cv_t'(e.sum));
                    check("cout", cv_t'(cout), cv_t'(e.cout));
                    check("ovf", cv_t'(ovf), cv_t'(e.ovf));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(exp_in);
                n_push++;
                acc = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input logic sb, input res_t e);
        bit acc;
        bit got;
        got = 1'b0;
        drive(x, y, ci, sb, e);
        for (int i = 0; i < 50 && !got; i++) begin
            tick(acc);
            got = acc;
        end
        check("send_accepted", cv_t'(got), cv_t'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < STAGES + 40 && q.size() > 0; i++) tick(acc);
        check("drain_empty", cv_t'(q.size()), cv_t'(0));
    endtask

    function automatic logic [WIDTH-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        bit               acc;
        int               lat;
        int               sent;
        int               cyc;
        int               pop0;
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs;
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] smax;
        logic [WIDTH-1:0] smin;

        ones = '1;
        smax = {1'b0, {(WIDTH-1){1'b1}}};
        smin = {1'b1, {(WIDTH-1){1'b0}}};

        // Reset held with a beat offered
        in_valid = 1'b1;
        a = 1;
        b = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", cv_t'(out_valid), cv_t'(0));
        check("rst_sum", cv_t'(sum), cv_t'(0));
        check("rst_in_ready", cv_t'(in_ready), cv_t'(1));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // Latency of a single beat
        out_ready = 1'b1;
        drive(3, 4, 1'b0, 1'b0, '{sum: 7, cout: 1'b0, ovf: 1'b0});
        tick(acc);
        check("accept_first", cv_t'(acc), cv_t'(1));
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < STAGES + 8) begin
            tick(acc);
            lat++;
        end
        check("latency", cv_t'(lat), cv_t'(STAGES - 1));
        drain();

        // Directed corner cases, back to back
        send(ones, 1, 1'b0, 1'b0, '{sum: '0, cout: 1'b1, ovf: 1'b0});
        send(5, 7, 1'b1, 1'b1, '{sum: ones - 1, cout: 1'b0, ovf: 1'b0});
        send(7, 5, 1'b0, 1'b1, '{sum: 2, cout: 1'b1, ovf: 1'b0});
        send(smax, 1, 1'b0, 1'b0, '{sum: smin, cout: 1'b0, ovf: 1'b1});
        send(smin, 1, 1'b0, 1'b1, '{sum: smax, cout: 1'b1, ovf: 1'b1});
        send(ones, ones, 1'b1, 1'b0, '{sum: ones, cout: 1'b1, ovf: 1'b0});
        drain();

        // Random beats under 1-0-0-1 backpressure
        pop0 = n_pop;
        sent = 0;
        cyc = 0;
        ra = rnd(); rb = rnd(); rc = 1'($urandom); rs = 1'($urandom);
        drive(ra, rb, rc, rs, model(ra, rb, rc, rs));
        while (sent < 16 && cyc < 400) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            tick(acc);
            cyc++;
            if (acc) begin
                sent++;
                ra = rnd(); rb = rnd(); rc = 1'($urandom); rs = 1'($urandom);
                drive(ra, rb, rc, rs, model(ra, rb, rc, rs));
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < STAGES + 60 && q.size() > 0; i++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            tick(acc);
            cyc++;
        end
        check("bp_sent", cv_t'(sent), cv_t'(16));
        check("bp_popped", cv_t'(n_pop - pop0), cv_t'(16));
        check("bp_queue_empty", cv_t'(q.size()), cv_t'(0));

        // Reset with beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra = rnd(); rb = rnd();
            drive(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
            tick(acc);
        end
        in_valid = 1'b0;
        tick(acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", cv_t'(out_valid), cv_t'(0));
        check("midrst_sum", cv_t'(sum), cv_t'(0));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        pop0 = n_pop;
        out_ready = 1'b1;
        for (int i = 0; i < STAGES + 4; i++) tick(acc);
        check("no_stale_out", cv_t'(n_pop - pop0), cv_t'(0));

        // Pipeline still works after reset
        send(ones, 1, 1'b0, 1'b0, '{sum: '0, cout: 1'b1, ovf: 1'b0});
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
